// File: rtl/note_seq_buffer_if.sv
// note_seq_buffer_if: record, playback and draw-request bus of note_seq_buffer.
interface note_seq_buffer_if #(
  parameter int NOTE_W = 4,
  parameter int OCT_W  = 2,
  parameter int AW     = 4,
  parameter int X_W    = 8,
  parameter int Y_W    = 7
);
  logic              rec_valid;
  logic              rec_ready;
  logic [NOTE_W-1:0] rec_note;
  logic [OCT_W-1:0]  rec_octave;
  logic              play_start;
  logic              play_stop;
  logic              step_tick;
  logic              clear;
  logic              play_active;
  logic              busy;
  logic              out_valid;
  logic [NOTE_W-1:0] out_note;
  logic [OCT_W-1:0]  out_octave;
  logic [AW-1:0]     out_slot;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              draw_valid;
  logic [X_W-1:0]    draw_x;
  logic [Y_W-1:0]    draw_y;
  logic [2:0]        draw_colour;
  modport slave (
    input  rec_valid, rec_note, rec_octave, play_start, play_stop, step_tick, clear,
    output rec_ready, play_active, busy, out_valid, out_note, out_octave, out_slot,
           count, full, empty, draw_valid, draw_x, draw_y, draw_colour
  );
  modport master (
    output rec_valid, rec_note, rec_octave, play_start, play_stop, step_tick, clear,
    input  rec_ready, play_active, busy, out_valid, out_note, out_octave, out_slot,
           count, full, empty, draw_valid, draw_x, draw_y, draw_colour
  );
endinterface

// File: rtl/note_seq_buffer.sv
// note_seq_buffer: circular note store with looped playback, bulk clear and per-slot draw requests.
module note_seq_buffer #(
  parameter int DEPTH     = 16,
  parameter int NOTE_W    = 4,
  parameter int OCT_W     = 2,
  parameter bit OVERWRITE = 1'b1,
  parameter int GRID_COLS = 4,
  parameter int CELL_W    = 36,
  parameter int CELL_H    = 12,
  parameter int GAP       = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7
) (
  input  logic clk,
  input  logic reset,
  note_seq_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = OCT_W + NOTE_W;
  typedef enum logic [1:0] {IDLE, PLAY, CLEAR} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, start_q, start_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d, out_slot_q, out_slot_d;
  logic [AW:0]   count_q, count_d;
  logic          out_valid_q, out_valid_d, draw_valid_q, draw_valid_d;
  logic [X_W-1:0] draw_x_q, draw_x_d;
  logic [Y_W-1:0] draw_y_q, draw_y_d;
  logic [2:0]    colour_q, colour_d;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q, wdata;
  logic [AW-1:0] waddr, draw_slot, last_slot;
  logic [2:0]    draw_col;
  logic          we, re, draw_go, full, empty, rec_fire;
  function automatic logic [X_W-1:0] cell_x(input logic [AW-1:0] s);
    return X_W'(GAP + (int'(s) % GRID_COLS) * (CELL_W + GAP));
  endfunction
  function automatic logic [Y_W-1:0] cell_y(input logic [AW-1:0] s);
    return Y_W'(GAP + (int'(s) / GRID_COLS) * (CELL_H + GAP));
  endfunction
  assign full      = count_q == (AW+1)'(DEPTH);
  assign empty     = count_q == '0;
  assign rec_fire  = bus.rec_valid && bus.rec_ready;
  assign last_slot = start_q + AW'(count_q - (AW+1)'(1));
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    start_d     = start_q;
    clr_ptr_d   = clr_ptr_q;
    count_d     = count_q;
    out_slot_d  = out_slot_q;
    out_valid_d = 1'b0;
    we          = 1'b0;
    re          = 1'b0;
    waddr       = wr_ptr_q;
    wdata       = {bus.rec_octave, bus.rec_note};
    draw_go     = 1'b0;
    draw_slot   = wr_ptr_q;
    draw_col    = 3'b100;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else if (bus.play_start && !empty) begin
          state_d  = PLAY;
          rd_ptr_d = (full && OVERWRITE) ? wr_ptr_q : '0;
          start_d  = (full && OVERWRITE) ? wr_ptr_q : '0;
        end else if (rec_fire) begin
          we       = 1'b1;
          draw_go  = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = full ? count_q : count_q + (AW+1)'(1);
        end
      end
      PLAY: begin
        if (bus.clear) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else if (bus.play_stop) begin
          state_d = IDLE;
        end else if (bus.step_tick) begin
          re          = 1'b1;
          out_valid_d = 1'b1;
          out_slot_d  = rd_ptr_q;
          draw_go     = 1'b1;
          draw_slot   = rd_ptr_q;
          draw_col    = 3'b110;
          // wrap back to the first played slot so only recorded slots loop
          rd_ptr_d    = (rd_ptr_q == last_slot) ? start_q : rd_ptr_q + AW'(1);
        end
      end
      CLEAR: begin
        we        = 1'b1;
        waddr     = clr_ptr_q;
        wdata     = '0;
        draw_go   = 1'b1;
        draw_slot = clr_ptr_q;
        draw_col  = 3'b000;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          start_d  = '0;
          count_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    draw_valid_d = draw_go;
    draw_x_d     = draw_go ? cell_x(draw_slot) : draw_x_q;
    draw_y_d     = draw_go ? cell_y(draw_slot) : draw_y_q;
    colour_d     = draw_go ? draw_col : colour_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      start_q      <= '0;
      clr_ptr_q    <= '0;
      count_q      <= '0;
      out_slot_q   <= '0;
      out_valid_q  <= 1'b0;
      draw_valid_q <= 1'b0;
      draw_x_q     <= '0;
      draw_y_q     <= '0;
      colour_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      start_q      <= start_d;
      clr_ptr_q    <= clr_ptr_d;
      count_q      <= count_d;
      out_slot_q   <= out_slot_d;
      out_valid_q  <= out_valid_d;
      draw_valid_q <= draw_valid_d;
      draw_x_q     <= draw_x_d;
      draw_y_q     <= draw_y_d;
      colour_q     <= colour_d;
    end
  end
  // storage is deliberately unreset so it maps onto plain synchronous RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[rd_ptr_q];
  end
  assign bus.rec_ready   = (state_q == IDLE) && (!full || OVERWRITE);
  assign bus.play_active = state_q == PLAY;
  assign bus.busy        = state_q == CLEAR;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_note    = out_valid_q ? rd_q[NOTE_W-1:0] : '0;
  assign bus.out_octave  = out_valid_q ? rd_q[DW-1:NOTE_W] : '0;
  assign bus.out_slot    = out_slot_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.draw_valid  = draw_valid_q;
  assign bus.draw_x      = draw_x_q;
  assign bus.draw_y      = draw_y_q;
  assign bus.draw_colour = colour_q;
endmodule

// File: tb/tb_note_seq_buffer.sv
// tb_note_seq_buffer: directed scoreboard bench for note_seq_buffer in both overwrite modes.
module tb_note_seq_buffer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  typedef struct { logic [5:0] d; logic [3:0] s; int c; } out_t;
  typedef struct { logic [7:0] x; logic [6:0] y; logic [2:0] col; int c; } drw_t;
  out_t oq[$];
  drw_t dq[$];
  logic [5:0] mm [16];
  int wp = 0, rp = 0, st = 0, cnt = 0;
  note_seq_buffer_if b0 ();
  note_seq_buffer_if b1 ();
  note_seq_buffer #(.OVERWRITE(1'b1)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  note_seq_buffer #(.OVERWRITE(1'b0)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] cx(input int s);
    return 8'(4 + (s % 4) * 40);
  endfunction
  function automatic logic [6:0] cy(input int s);
    return 7'(4 + (s / 4) * 16);
  endfunction
  always @(negedge clk) begin
    out_t e;
    drw_t f;
    if (!reset) begin
      if (oq.size() > 0 && oq[0].c == cyc) begin
        e = oq.pop_front();
        chk("out_valid", b0.out_valid, 1);
        chk("out_data", {b0.out_octave, b0.out_note}, e.d);
        chk("out_slot", b0.out_slot, e.s);
      end else if (b0.out_valid) chk("out_unexpected", b0.out_valid, 0);
      if (dq.size() > 0 && dq[0].c == cyc) begin
        f = dq.pop_front();
        chk("draw_valid", b0.draw_valid, 1);
        chk("draw_x", b0.draw_x, f.x);
        chk("draw_y", b0.draw_y, f.y);
        chk("draw_colour", b0.draw_colour, f.col);
      end else if (b0.draw_valid) chk("draw_unexpected", b0.draw_valid, 0);
    end
  end
  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_ctl"}, {b0.count, b0.empty, b0.full, b0.rec_ready, b0.play_active,
                        b0.busy, b0.out_valid, b0.draw_valid}, {5'd0, 1'b1, 1'b0, 1'b1, 4'b0000});
    chk({tag, "_data"}, {b0.out_note, b0.out_octave, b0.out_slot, b0.draw_x, b0.draw_y,
                         b0.draw_colour}, '0);
  endtask
  task automatic rec(input logic [1:0] o, input logic [3:0] n);
    chk("rec_ready", b0.rec_ready, 1);
    b0.rec_valid = 1'b1;
    b0.rec_octave = o;
    b0.rec_note = n;
    dq.push_back('{x: cx(wp), y: cy(wp), col: 3'b100, c: cyc + 1});
    mm[wp] = {o, n};
    wp = (wp + 1) % 16;
    if (cnt < 16) cnt++;
    cyc_step();
    b0.rec_valid = 1'b0;
  endtask
  task automatic start_play();
    b0.play_start = 1'b1;
    if (cnt > 0) begin
      rp = (cnt == 16) ? wp : 0;
      st = rp;
    end
    cyc_step();
    b0.play_start = 1'b0;
    chk("play_active", b0.play_active, cnt > 0);
  endtask
  task automatic step();
    b0.step_tick = 1'b1;
    oq.push_back('{d: mm[rp], s: 4'(rp), c: cyc + 1});
    dq.push_back('{x: cx(rp), y: cy(rp), col: 3'b110, c: cyc + 1});
    rp = (((rp - st + 16) % 16) + 1 == cnt) ? st : (rp + 1) % 16;
    cyc_step();
    b0.step_tick = 1'b0;
  endtask
  task automatic do_clear(input bit poke, input bit combo);
    b0.clear = 1'b1;
    if (combo) begin
      b0.play_start = 1'b1;
      b0.rec_valid = 1'b1;
      b0.rec_note = 4'hA;
      b0.rec_octave = 2'd1;
    end
    for (int k = 0; k < 16; k++) dq.push_back('{x: cx(k), y: cy(k), col: 3'b000, c: cyc + 2 + k});
    cyc_step();
    {b0.clear, b0.play_start, b0.rec_valid} = '0;
    for (int k = 0; k < 16; k++) begin
      chk("clr_busy", b0.busy, 1);
      chk("clr_play_active", b0.play_active, 0);
      if (poke && k == 3) {b0.clear, b0.play_start, b0.step_tick, b0.rec_valid} = '1;
      cyc_step();
      {b0.clear, b0.play_start, b0.step_tick, b0.rec_valid} = '0;
    end
    chk("clr_done_busy", b0.busy, 0);
    chk("clr_done_count", b0.count, 0);
    chk("clr_done_empty", b0.empty, 1);
    wp = 0; rp = 0; st = 0; cnt = 0;
    for (int m = 0; m < 16; m++) mm[m] = '0;
  endtask
  task automatic mid_reset(input string tag);
    #1 reset = 1'b1;
    #1 reset_vals(tag);
    oq.delete();
    dq.delete();
    wp = 0; rp = 0; st = 0; cnt = 0;
    reset = 1'b0;
    cyc_step();
  endtask
  initial begin
    reset = 1'b1;
    {b0.rec_valid, b0.rec_note, b0.rec_octave, b0.play_start, b0.play_stop, b0.step_tick, b0.clear} = '0;
    {b1.rec_valid, b1.rec_note, b1.rec_octave, b1.play_start, b1.play_stop, b1.step_tick, b1.clear} = '0;
    cyc_step();
    cyc_step();
    reset_vals("reset");
    chk("u1_reset", {b1.rec_ready, b1.empty, b1.count}, {1'b1, 1'b1, 5'd0});
    #2 reset = 1'b0;
    cyc_step();
    rec(2'd1, 4'd5);
    rec(2'd2, 4'd3);
    rec(2'd0, 4'd9);
    chk("count3", b0.count, 3);
    start_play();
    repeat (4) step();
    b0.play_stop = 1'b1;
    cyc_step();
    b0.play_stop = 1'b0;
    chk("stopped", b0.play_active, 0);
    for (int i = 3; i <= 16; i++) rec(2'((i / 4) % 4), 4'(i % 16));
    chk("full_count", b0.count, 16);
    chk("full_flag", b0.full, 1);
    chk("full_rec_ready_ow", b0.rec_ready, 1);
    start_play();
    repeat (17) step();
    cyc_step();
    do_clear(1'b1, 1'b0);
    start_play();
    cyc_step();
    chk("play_after_clear", b0.play_active, 0);
    rec(2'd3, 4'd3);
    do_clear(1'b0, 1'b1);
    rec(2'd1, 4'd1);
    rec(2'd2, 4'd2);
    start_play();
    step();
    step();
    mid_reset("mid_play");
    rec(2'd3, 4'd7);
    start_play();
    step();
    b0.play_stop = 1'b1;
    cyc_step();
    b0.play_stop = 1'b0;
    b0.clear = 1'b1;
    for (int k = 0; k < 16; k++) dq.push_back('{x: cx(k), y: cy(k), col: 3'b000, c: cyc + 2 + k});
    cyc_step();
    b0.clear = 1'b0;
    repeat (5) cyc_step();
    chk("mid_clr_busy", b0.busy, 1);
    mid_reset("mid_clr");
    rec(2'd0, 4'd4);
    chk("after_reset_count", b0.count, 1);
    for (int i = 0; i < 16; i++) begin
      chk("u1_rec_ready", b1.rec_ready, 1);
      b1.rec_valid = 1'b1;
      b1.rec_octave = 2'd1;
      b1.rec_note = 4'(i);
      cyc_step();
      b1.rec_valid = 1'b0;
    end
    chk("u1_full", {b1.rec_ready, b1.full, b1.count}, {1'b0, 1'b1, 5'd16});
    b1.rec_valid = 1'b1;
    b1.rec_note = 4'hF;
    cyc_step();
    b1.rec_valid = 1'b0;
    chk("u1_count_held", b1.count, 16);
    b1.play_start = 1'b1;
    cyc_step();
    b1.play_start = 1'b0;
    b1.step_tick = 1'b1;
    cyc_step();
    b1.step_tick = 1'b0;
    chk("u1_out", {b1.out_valid, b1.out_slot, b1.out_octave, b1.out_note}, {1'b1, 4'd0, 6'h10});
    repeat (3) cyc_step();
    chk("out_queue_drained", oq.size(), 0);
    chk("draw_queue_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
